// File: rtl/str_ring_emulator_if.sv
// Control/observation bundle for str_ring_emulator.
// master: the side that drives load/run/mask (bench or host logic).
// slave: the emulator itself.
interface str_ring_emulator_if #(
  parameter int N_STAGES = 30,
  parameter int CNT_W    = 16
);
  logic                MODE;
  logic                LOAD_VALID;
  logic                LOAD_READY;
  logic [N_STAGES-1:0] LOAD_STATE;
  logic                RUN;
  logic [N_STAGES-1:0] FIRE_MASK;
  logic [N_STAGES-1:0] STATE;
  logic                TAP_OUT;
  logic                DEADLOCK;
  logic [CNT_W-1:0]    EDGE_COUNT;
  logic [CNT_W-1:0]    PERIOD;
  logic                PERIOD_VALID;

  modport master (
    output MODE, LOAD_VALID, LOAD_STATE, RUN, FIRE_MASK,
    input  LOAD_READY, STATE, TAP_OUT, DEADLOCK, EDGE_COUNT, PERIOD, PERIOD_VALID
  );

  modport slave (
    input  MODE, LOAD_VALID, LOAD_STATE, RUN, FIRE_MASK,
    output LOAD_READY, STATE, TAP_OUT, DEADLOCK, EDGE_COUNT, PERIOD, PERIOD_VALID
  );
endinterface

// File: rtl/str_ring_emulator.sv
// Clocked emulator of an N_STAGES self-timed ring (NOR funnel rule or
// Muller-C STR rule) with load/run control, per-stage fire masking,
// deadlock detection and edge/period measurement on stage TAP.
// Optional feature macro: STR_RANDOM_FIRE_EN (LFSR-gated fire mask that
// emulates stage delay spread). Undefined by default.
module str_ring_emulator #(
  parameter int                  N_STAGES   = 30,
  parameter int                  TAP        = 0,
  parameter int                  CNT_W      = 16,
  parameter logic [N_STAGES-1:0] INIT_STATE = '0
) (
  input logic                 CLK,
  input logic                 RESET_N,
  str_ring_emulator_if.slave  bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUNNING, ST_DEADLOCK} fsm_t;

  fsm_t                fsm_q, fsm_d;
  logic [N_STAGES-1:0] state_q, state_d;
  logic [N_STAGES-1:0] cand, mask, upd;
  logic [CNT_W-1:0]    edge_cnt_q, period_q, timer_q;
  logic                period_vld_q, seen_rise_q;
  logic                do_load, do_update, running, tap_chg, tap_rise;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // Per-stage candidate: every stage sees its wrapped predecessor/successor.
  for (genvar i = 0; i < N_STAGES; i++) begin : g_cell
    localparam int P  = (i + N_STAGES - 1) % N_STAGES;
    localparam int NX = (i + 1) % N_STAGES;
    assign cand[i] = bus.MODE ? ((state_q[P] != state_q[NX]) ? state_q[P] : state_q[i])
                              : (~state_q[P] & state_q[NX]);
  end

`ifdef STR_RANDOM_FIRE_EN
  logic [15:0] lfsr_q;

  // Fibonacci LFSR (taps 16,14,13,11); steps once per RUNNING cycle.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)     lfsr_q <= 16'hACE1;
    else if (running) lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  for (genvar i = 0; i < N_STAGES; i++) begin : g_mask
    localparam int L = i % 16;
    assign mask[i] = bus.FIRE_MASK[i] & lfsr_q[L];
  end
`else
  assign mask = bus.FIRE_MASK;
`endif

  // Stages that are allowed to fire take their candidate; the rest hold.
  assign upd = (mask & cand) | (~mask & state_q);

  // FSM state register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) fsm_q <= ST_IDLE;
    else          fsm_q <= fsm_d;
  end

  // FSM next state; deadlock uses the unmasked candidate so a zero mask never trips it.
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      ST_IDLE:     if (!bus.LOAD_VALID && bus.RUN) fsm_d = ST_RUNNING;
      ST_RUNNING:  if (!bus.RUN)                   fsm_d = ST_IDLE;
                   else if (cand == state_q)       fsm_d = ST_DEADLOCK;
      ST_DEADLOCK: if (!bus.RUN)                   fsm_d = ST_IDLE;
      default:     fsm_d = ST_IDLE;
    endcase
  end

  // FSM outputs and datapath strobes.
  always_comb begin
    running   = (fsm_q == ST_RUNNING);
    do_load   = (fsm_q == ST_IDLE) && bus.LOAD_VALID;
    do_update = running && bus.RUN;
    state_d   = do_load ? bus.LOAD_STATE : (do_update ? upd : state_q);
    tap_chg   = do_update && (upd[TAP] != state_q[TAP]);
    tap_rise  = do_update && upd[TAP] && !state_q[TAP];
  end

  // Stage vector register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= INIT_STATE;
    else          state_q <= state_d;
  end

  // Tap edge counter, period timer and period capture.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      edge_cnt_q   <= '0;
      period_q     <= '0;
      timer_q      <= '0;
      period_vld_q <= 1'b0;
      seen_rise_q  <= 1'b0;
    end else if (do_load) begin
      edge_cnt_q   <= '0;
      period_q     <= '0;
      timer_q      <= '0;
      period_vld_q <= 1'b0;
      seen_rise_q  <= 1'b0;
    end else begin
      period_vld_q <= 1'b0;
      if (tap_chg) edge_cnt_q <= sat_inc(edge_cnt_q);
      if (tap_rise) begin
        if (seen_rise_q) begin
          period_q     <= sat_inc(timer_q);
          period_vld_q <= 1'b1;
        end
        seen_rise_q <= 1'b1;
        timer_q     <= '0;
      end else if (running) begin
        timer_q <= sat_inc(timer_q);
      end
    end
  end

  assign bus.STATE        = state_q;
  assign bus.TAP_OUT      = state_q[TAP];
  assign bus.LOAD_READY   = (fsm_q == ST_IDLE);
  assign bus.DEADLOCK     = (fsm_q == ST_DEADLOCK);
  assign bus.EDGE_COUNT   = edge_cnt_q;
  assign bus.PERIOD       = period_q;
  assign bus.PERIOD_VALID = period_vld_q;

endmodule
